cpu_output_pio_ext: RTL and testbench

Parametrised Avalon-MM output PIO for the Nios CPU subsystem, successor to the fixed 8-bit output port. Adds configurable width, a reset value, atomic bit-set and bit-clear registers, and a hardware pulse engine. The pulse engine inverts selected output bits for a programmable number of clock cycles, then restores them. Sits on the CPU data master as a zero-wait-state slave and drives board-level signals such as LEDs, strobes and classifier control lines.

---
 rtl/cpu_pio_pkg.sv | 12 +
 rtl/cpu_pio_pulse_timer.sv | 55 +++++
 rtl/cpu_output_pio_ext.sv | 137 +++++++++++++
 tb/tb_cpu_output_pio_ext.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pio_pkg.sv
// Shared constants for the Nios output PIO: bus width and word addresses.
package cpu_pio_pkg;

   localparam int BUS_WIDTH = 32;

   localparam logic [2:0] ADDR_DATA   = 3'd0;
   localparam logic [2:0] ADDR_PULSE  = 3'd1;
   localparam logic [2:0] ADDR_LEN    = 3'd2;
   localparam logic [2:0] ADDR_OUTSET = 3'd4;
   localparam logic [2:0] ADDR_OUTCLR = 3'd5;

endpackage

// File: rtl/cpu_pio_pulse_timer.sv
// Pulse engine: one shared down-counter and an inversion mask. A trigger with
// a nonzero mask ORs bits into the mask and reloads the counter with
// max(len,1)-1; the whole mask clears on the edge after the counter hits 0.
module cpu_pio_pulse_timer #(
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  trigger,
   input  logic [DATA_WIDTH-1:0] mask,
   input  logic [LEN_WIDTH-1:0]  len,
   output logic [DATA_WIDTH-1:0] pulse_active
);

   localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

   logic [LEN_WIDTH-1:0]  cnt_reg, cnt_next, eff_len_m1;
   logic [DATA_WIDTH-1:0] active_reg, active_next;

   // Reload value: a length of 0 is treated as a 1-cycle pulse.
   always_comb begin
      eff_len_m1 = (len == '0) ? '0 : (len - LEN_ONE);
   end

   // Next state: a trigger wins over both countdown and expiry.
   always_comb begin
      active_next = active_reg;
      cnt_next    = cnt_reg;
      if (trigger && (mask != '0)) begin
         active_next = active_reg | mask;
         cnt_next    = eff_len_m1;
      end else if (active_reg != '0) begin
         if (cnt_reg != '0) begin
            cnt_next = cnt_reg - LEN_ONE;
         end else begin
            active_next = '0;
         end
      end
   end

   // State registers; reset aborts any pulse in progress.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_reg    <= '0;
         active_reg <= '0;
      end else begin
         cnt_reg    <= cnt_next;
         active_reg <= active_next;
      end
   end

   assign pulse_active = active_reg;

endmodule

// File: rtl/cpu_output_pio_ext.sv
// Parametrised Avalon-MM output PIO with atomic set/clear and optional pulse
// engine. Define CPU_OUTPUT_PIO_PULSE_EN to build the PULSE/LEN registers
// and the pulse timer; otherwise addresses 1 and 2 are reserved.
module cpu_output_pio_ext
   import cpu_pio_pkg::*;
#(
   parameter int                    DATA_WIDTH   = 8,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE  = '0,
   parameter int                    PULSE_CYCLES = 1000,
   parameter int                    LEN_WIDTH    = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [2:0]            address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic [BUS_WIDTH-1:0]  writedata,
   output logic [BUS_WIDTH-1:0]  readdata,
   output logic [DATA_WIDTH-1:0] out_port
);

   logic                  wr_en;
   logic [DATA_WIDTH-1:0] wdata;
   logic [DATA_WIDTH-1:0] data_reg, data_next;
   logic [BUS_WIDTH-1:0]  data_ext;
   logic                  unused_wdata;

   assign wr_en        = chipselect & ~write_n;
   assign wdata        = writedata[DATA_WIDTH-1:0];
   assign unused_wdata = ^writedata;

   // Data register update: full write, atomic set, atomic clear.
   always_comb begin
      data_next = data_reg;
      if (wr_en) begin
         case (address)
            ADDR_DATA:   data_next = wdata;
            ADDR_OUTSET: data_next = data_reg | wdata;
            ADDR_OUTCLR: data_next = data_reg & ~wdata;
            default:     data_next = data_reg;
         endcase
      end
   end

   // Data register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_reg <= RESET_VALUE;
      end else begin
         data_reg <= data_next;
      end
   end

   generate
      for (genvar gi = 0; gi < BUS_WIDTH; gi++) begin : g_data_ext
         if (gi < DATA_WIDTH) begin : g_bit
            assign data_ext[gi] = data_reg[gi];
         end else begin : g_zero
            assign data_ext[gi] = 1'b0;
         end
      end
   endgenerate

`ifdef CPU_OUTPUT_PIO_PULSE_EN
   localparam logic [LEN_WIDTH-1:0] LEN_RESET = LEN_WIDTH'(PULSE_CYCLES);

   logic [LEN_WIDTH-1:0]  len_reg;
   logic [DATA_WIDTH-1:0] pulse_active;
   logic                  pulse_trigger;
   logic [BUS_WIDTH-1:0]  active_ext, len_ext;

   assign pulse_trigger = wr_en && (address == ADDR_PULSE);

   // Pulse-length register; only consulted at the next trigger.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         len_reg <= LEN_RESET;
      end else if (wr_en && (address == ADDR_LEN)) begin
         len_reg <= writedata[LEN_WIDTH-1:0];
      end
   end

   cpu_pio_pulse_timer #(
      .DATA_WIDTH (DATA_WIDTH),
      .LEN_WIDTH  (LEN_WIDTH)
   ) u_pulse_timer (
      .clk          (clk),
      .reset_n      (reset_n),
      .trigger      (pulse_trigger),
      .mask         (wdata),
      .len          (len_reg),
      .pulse_active (pulse_active)
   );

   generate
      for (genvar gi = 0; gi < BUS_WIDTH; gi++) begin : g_pulse_ext
         if (gi < DATA_WIDTH) begin : g_act
            assign active_ext[gi] = pulse_active[gi];
         end else begin : g_act_zero
            assign active_ext[gi] = 1'b0;
         end
         if (gi < LEN_WIDTH) begin : g_len
            assign len_ext[gi] = len_reg[gi];
         end else begin : g_len_zero
            assign len_ext[gi] = 1'b0;
         end
      end
   endgenerate

   assign out_port = data_reg ^ pulse_active;

   // Read mux: pure function of address, independent of chipselect.
   always_comb begin
      readdata = '0;
      case (address)
         ADDR_DATA:  readdata = data_ext;
         ADDR_PULSE: readdata = active_ext;
         ADDR_LEN:   readdata = len_ext;
         default:    readdata = '0;
      endcase
   end
`else
   logic unused_cfg;

   assign unused_cfg = ^{LEN_WIDTH, PULSE_CYCLES};
   assign out_port   = data_reg;

   // Read mux: only DATA is readable without the pulse engine.
   always_comb begin
      readdata = '0;
      if (address == ADDR_DATA) begin
         readdata = data_ext;
      end
   end
`endif

endmodule

// File: tb/tb_cpu_output_pio_ext.sv
// Self-checking bench for cpu_output_pio_ext (DATA_WIDTH=8, RESET_VALUE=A5).
// Reference model tracks pulse expiry as an absolute edge number.
module tb_cpu_output_pio_ext;

   logic        clk;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [7:0]  out_port;

   int n_cmp  = 0;
   int n_fail = 0;

`ifdef CPU_OUTPUT_PIO_PULSE_EN
   localparam bit PULSE_EN = 1'b1;
`else
   localparam bit PULSE_EN = 1'b0;
`endif

   // reference model state
   logic [7:0]  m_data;
   logic [7:0]  m_mask;
   logic [15:0] m_len;
   longint      m_end;
   longint      edge_n;

   cpu_output_pio_ext #(
      .DATA_WIDTH   (8),
      .RESET_VALUE  (8'hA5),
      .PULSE_CYCLES (1000),
      .LEN_WIDTH    (16)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] model_out();
      return m_data ^ m_mask;
   endfunction

   function automatic logic [31:0] model_read(input logic [2:0] a);
      case (a)
         3'd0:    return {24'd0, m_data};
         3'd1:    return PULSE_EN ? {24'd0, m_mask} : 32'd0;
         3'd2:    return PULSE_EN ? {16'd0, m_len} : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_reset();
      m_data = 8'hA5;
      m_mask = 8'h00;
      m_len  = 16'd1000;
      m_end  = 0;
   endtask

   // Apply the current bus inputs to the model at one rising edge.
   task automatic model_edge();
      logic       wr;
      logic [7:0] m;
      longint     eff;
      wr = chipselect && !write_n;
      m  = writedata[7:0];
      if (PULSE_EN && wr && address == 3'd1 && m != 8'h00) begin
         eff    = (m_len == 16'd0) ? 1 : longint'(m_len);
         m_mask = m_mask | m;
         m_end  = edge_n + eff;
      end else if (m_mask != 8'h00 && edge_n >= m_end) begin
         m_mask = 8'h00;
      end
      if (wr) begin
         case (address)
            3'd0: m_data = m;
            3'd4: m_data = m_data | m;
            3'd5: m_data = m_data & ~m;
            3'd2: if (PULSE_EN) m_len = writedata[15:0];
            default: ;
         endcase
      end
   endtask

   task automatic step();
      @(posedge clk);
      edge_n++;
      model_edge();
      #1;
   endtask

   task automatic bus_idle();
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 32'd0;
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b0;
      writedata  = d;
      step();
      bus_idle();
   endtask

   task automatic test_reset();
      logic [31:0] exp_rd [3];
      exp_rd[0] = 32'hA5;
      exp_rd[1] = 32'd0;
      exp_rd[2] = PULSE_EN ? 32'd1000 : 32'd0;
      n_cmp++;
      if (out_port !== 8'hA5) begin
         n_fail++;
         $display("FAIL reset_out_port: got %h want a5", out_port);
      end
      for (int a = 0; a < 3; a++) begin
         address = 3'(a);
         #1;
         n_cmp++;
         if (readdata !== exp_rd[a]) begin
            n_fail++;
            $display("FAIL reset_read[%0d]: got %h want %h", a, readdata, exp_rd[a]);
         end
      end
      $display("test_reset: out=%h", out_port);
   endtask

   task automatic test_set_clr();
      logic [2:0] addrs [3];
      logic [7:0] vals  [3];
      logic [7:0] exps  [3];
      addrs = '{3'd0, 3'd4, 3'd5};
      vals  = '{8'h0F, 8'h30, 8'h05};
      exps  = '{8'h0F, 8'h3F, 8'h3A};
      for (int i = 0; i < 3; i++) begin
         bus_write(addrs[i], {24'hFFFF00, vals[i]});
         n_cmp++;
         if (out_port !== exps[i]) begin
            n_fail++;
            $display("FAIL set_clr[%0d]: got %h want %h", i, out_port, exps[i]);
         end
         $display("test_set_clr: addr=%0d wd=%h out=%h", addrs[i], vals[i], out_port);
      end
      address = 3'd0;
      #1;
      n_cmp++;
      if (readdata !== 32'h3A) begin
         n_fail++;
         $display("FAIL set_clr_readback: got %h want 0000003a", readdata);
      end
      address = 3'd4;
      #1;
      n_cmp++;
      if (readdata !== 32'd0) begin
         n_fail++;
         $display("FAIL outset_read: got %h want 0", readdata);
      end
   endtask

   task automatic test_pulse_len3();
      logic [7:0] exp;
      bus_write(3'd2, 32'd3);
      bus_write(3'd0, 32'd0);
      bus_write(3'd1, 32'h01);
      for (int i = 0; i < 5; i++) begin
         exp = (PULSE_EN && i < 3) ? 8'h01 : 8'h00;
         n_cmp++;
         if (out_port !== exp) begin
            n_fail++;
            $display("FAIL pulse_len3 cyc%0d: got %h want %h", i, out_port, exp);
         end
         $display("test_pulse_len3: cyc=%0d out=%h", i, out_port);
         step();
      end
   endtask

   task automatic test_retrigger();
      logic [7:0] exp;
      bus_write(3'd2, 32'd4);
      bus_write(3'd1, 32'h01);          // edge N
      step();                           // edge N+1
      bus_write(3'd1, 32'h02);          // edge N+2
      // i counts edges from N+2
      for (int i = 0; i < 6; i++) begin
         exp = (PULSE_EN && i < 4) ? 8'h03 : 8'h00;
         n_cmp++;
         if (out_port !== exp) begin
            n_fail++;
            $display("FAIL retrigger edge N+%0d: got %h want %h", i + 2, out_port, exp);
         end
         $display("test_retrigger: edge=N+%0d out=%h", i + 2, out_port);
         step();
      end
   endtask

   task automatic test_len0();
      bus_write(3'd2, 32'd0);
      bus_write(3'd1, 32'h80);
      n_cmp++;
      if (out_port !== (PULSE_EN ? 8'h80 : 8'h00)) begin
         n_fail++;
         $display("FAIL len0_pulse: got %h want %h", out_port, PULSE_EN ? 8'h80 : 8'h00);
      end
      step();
      n_cmp++;
      if (out_port !== 8'h00) begin
         n_fail++;
         $display("FAIL len0_restore: got %h want 00", out_port);
      end
      bus_write(3'd1, 32'h00);
      n_cmp++;
      if (out_port !== 8'h00) begin
         n_fail++;
         $display("FAIL zero_mask: got %h want 00", out_port);
      end
      $display("test_len0: out=%h", out_port);
   endtask

   task automatic test_random();
      logic [2:0] a;
      for (int i = 0; i < 400; i++) begin
         a          = 3'($urandom_range(0, 7));
         address    = a;
         chipselect = 1'($urandom_range(0, 1));
         write_n    = ($urandom_range(0, 3) == 0);
         writedata  = $urandom;
         if (a == 3'd2) writedata = 32'($urandom_range(0, 6));
         if (a == 3'd1 && $urandom_range(0, 3) == 0) writedata = 32'hFFFFFF00;
         step();
         bus_idle();
         n_cmp++;
         if (out_port !== model_out()) begin
            n_fail++;
            $display("FAIL random_out[%0d]: got %h want %h", i, out_port, model_out());
         end
         address = 3'($urandom_range(0, 7));
         #1;
         n_cmp++;
         if (readdata !== model_read(address)) begin
            n_fail++;
            $display("FAIL random_read[%0d] addr=%0d: got %h want %h",
                     i, address, readdata, model_read(address));
         end
         if (i % 50 == 0)
            $display("test_random: txn=%0d out=%h", i, out_port);
      end
   endtask

   task automatic test_reset_mid_pulse();
      bus_write(3'd2, 32'd10);
      bus_write(3'd1, 32'hFF);
      step();
      #3;
      reset_n = 1'b0;
      model_reset();
      #1;
      n_cmp++;
      if (out_port !== 8'hA5) begin
         n_fail++;
         $display("FAIL reset_mid_out: got %h want a5", out_port);
      end
      address = 3'd1;
      #1;
      n_cmp++;
      if (readdata !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_mid_pulse_read: got %h want 0", readdata);
      end
      $display("test_reset_mid_pulse: out=%h", out_port);
      @(negedge clk);
      reset_n = 1'b1;
      step();
      n_cmp++;
      if (out_port !== 8'hA5) begin
         n_fail++;
         $display("FAIL reset_mid_after: got %h want a5", out_port);
      end
   endtask

   initial begin
      edge_n  = 0;
      reset_n = 1'b0;
      address = 3'd0;
      bus_idle();
      model_reset();
      #23;
      reset_n = 1'b1;
      #1;
      test_reset();
      test_set_clr();
      test_pulse_len3();
      test_retrigger();
      test_len0();
      test_random();
      test_reset_mid_pulse();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
